// File: rtl/pipeline_pkg.sv
// Shared constants and helpers for the elastic pipeline slice.
package pipeline_pkg;

    // Default geometry of the project pipeline slice.
    localparam int PIPE_WIDTH = 32;
    localparam int PIPE_DEPTH = 5;

    // Width of the mask helper result. Callers slice it down to their data
    // width, so stage data widths up to this value are supported.
    localparam int MASK_W = 256;

    // One-hot mask applied by stage k; the bit index wraps at the data width
    // so pipelines deeper than they are wide keep working.
    function automatic logic [MASK_W-1:0] stage_mask(input int unsigned k,
                                                     input int unsigned width);
        return MASK_W'(1) << (k % width);
    endfunction

endpackage

// File: rtl/pipeline_stage.sv
// One register slice of the elastic pipeline: a valid bit plus a data word.
// The stage ORs its constant mask into the data as it loads, standing in for
// real per-stage logic.
module pipeline_stage #(
    parameter int               WIDTH = 32,
    parameter logic [WIDTH-1:0] MASK  = '0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             i_load,
    input  logic             i_flush,
    input  logic             i_valid,
    input  logic [WIDTH-1:0] i_data,
    output logic             o_valid,
    output logic [WIDTH-1:0] o_data
);

    logic             r_valid;
    logic [WIDTH-1:0] r_data;

    // Flush drops the item but leaves data alone; a load with no upstream
    // item creates a bubble without disturbing the held data.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_valid <= 1'b0;
            r_data  <= '0;
        end else if (i_flush) begin
            r_valid <= 1'b0;
        end else if (i_load) begin
            r_valid <= i_valid;
            if (i_valid) begin
                r_data <= i_data | MASK;
            end
        end
    end

    assign o_valid = r_valid;
    assign o_data  = r_data;

endmodule

// File: rtl/elastic_pipeline.sv
// Elastic DEPTH-stage pipeline slice with ready/valid on both sides.
// Empty stages always accept, so bubbles collapse and a stalled consumer
// lets the pipeline fill completely before pushing back on the producer.
module elastic_pipeline
    import pipeline_pkg::*;
#(
    parameter int WIDTH = PIPE_WIDTH,
    parameter int DEPTH = PIPE_DEPTH,
    parameter int OCC_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             flush,
    output logic [WIDTH-1:0] out_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [OCC_W-1:0] occupancy
);

    logic [DEPTH:0]   w_adv;
    logic [DEPTH-1:0] w_valid;
    logic [WIDTH-1:0] w_data [DEPTH];
    logic             w_accept;
    logic             w_out_hs;
    logic [OCC_W-1:0] r_occ;

    // Advance chain: a stage may move when it is empty or its successor moves.
    // Built back to front so the chain resolves in one pass.
    always_comb begin
        w_adv        = '0;
        w_adv[DEPTH] = out_ready;
        for (int k = DEPTH - 1; k >= 0; k--) begin
            w_adv[k] = !w_valid[k] || w_adv[k+1];
        end
    end

    assign in_ready = w_adv[0] && !flush;
    assign w_accept = in_valid && in_ready;
    assign w_out_hs = w_valid[DEPTH-1] && out_ready;

    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_stage
            localparam logic [MASK_W-1:0] L_MASK =
                stage_mask(unsigned'(gi), unsigned'(WIDTH));

            logic             w_up_valid;
            logic [WIDTH-1:0] w_up_data;

            if (gi == 0) begin : g_head
                assign w_up_valid = w_accept;
                assign w_up_data  = in_data;
            end else begin : g_body
                assign w_up_valid = w_valid[gi-1];
                assign w_up_data  = w_data[gi-1];
            end

            pipeline_stage #(
                .WIDTH (WIDTH),
                .MASK  (L_MASK[WIDTH-1:0])
            ) u_stage (
                .clk     (clk),
                .reset   (reset),
                .i_load  (w_adv[gi]),
                .i_flush (flush),
                .i_valid (w_up_valid),
                .i_data  (w_up_data),
                .o_valid (w_valid[gi]),
                .o_data  (w_data[gi])
            );
        end
    endgenerate

    // Occupancy tracks accepts minus deliveries; a flush empties everything,
    // including any item the consumer takes in that same cycle.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_occ <= '0;
        end else if (flush) begin
            r_occ <= '0;
        end else if (w_accept && !w_out_hs) begin
            r_occ <= r_occ + OCC_W'(1);
        end else if (!w_accept && w_out_hs) begin
            r_occ <= r_occ - OCC_W'(1);
        end
    end

    // The counter is a cheap mirror of the valid bits; keep them in lock-step.
    a_occ_matches_valid : assert property (
        @(posedge clk) disable iff (reset)
        r_occ == OCC_W'($countones(w_valid))
    );

    assign out_data  = w_data[DEPTH-1];
    assign out_valid = w_valid[DEPTH-1];
    assign occupancy = r_occ;

endmodule
